// File: rtl/data_ram_responder_if.sv
// rtl/data_ram_responder_if.sv - memory FU request/response handshake bundle
interface data_ram_responder_if;
  logic        cs;
  logic        we;
  logic [2:0]  bhw;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;
  logic        ack;
  logic        err;

  modport master (output cs, we, bhw, addr, din, input dout, stall, ack, err);
  modport slave  (input cs, we, bhw, addr, din, output dout, stall, ack, err);
endinterface

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - byte-addressable data RAM with fixed access latency
module data_ram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input logic                 clk,
  input logic                 rst,
  data_ram_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        bhw_q, bhw_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic              access;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]        lane;
  logic [1:0]        size;
  logic              bad;
  logic              wr_en;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       word;
  logic [31:0]       ldata;
  logic [7:0]        lbyte;
  logic [15:0]       lhalf;
  logic              unused_addr;

  assign unused_addr = ^bus.addr[31:AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bhw_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      bhw_q   <= bhw_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Request fields are latched only on acceptance; BUSY ignores the bus entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bhw_d   = bhw_q;
    addr_d  = addr_q;
    din_d   = din_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (bus.cs) begin
          state_d = S_BUSY;
          cnt_d   = 4'(LATENCY - 1);
          we_d    = bus.we;
          bhw_d   = bus.bhw;
          addr_d  = bus.addr[AW-1:0];
          din_d   = bus.din;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx   = addr_q[AW-1:2];
    lane  = addr_q[1:0];
    size  = bhw_q[1:0];
    word  = mem[idx];
    bad   = (bhw_q == 3'b011) || (bhw_q == 3'b110) || (bhw_q == 3'b111) ||
            ((size == 2'b01) && addr_q[0]) ||
            ((size == 2'b10) && (lane != 2'b00));
    lbyte = word[{lane, 3'b000} +: 8];
    lhalf = lane[1] ? word[31:16] : word[15:0];
    case (bhw_q)
      3'b000:  ldata = {{24{lbyte[7]}}, lbyte};
      3'b100:  ldata = {24'b0, lbyte};
      3'b001:  ldata = {{16{lhalf[15]}}, lhalf};
      3'b101:  ldata = {16'b0, lhalf};
      default: ldata = word;
    endcase
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (size)
      2'b00:   wdata = {4{din_q[7:0]}};
      2'b01:   wdata = {2{din_q[15:0]}};
      default: wdata = din_q;
    endcase
    wr_en  = access && we_q && !bad;
    err_d  = access ? bad : err_q;
    dout_d = (access && !we_q && !bad) ? ldata : dout_q;
  end

  // Array is deliberately outside the reset domain so reset never clears contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.stall = (state_q == S_BUSY);
    bus.ack   = (state_q == S_RESP);
    bus.err   = (state_q == S_RESP) && err_q;
    bus.dout  = dout_q;
  end
endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - self-checking bench for data_ram_responder
module tb_data_ram_responder;
  localparam int L0 = 3, AW0 = 10;
  localparam int L1 = 1, AW1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_responder_if b0 ();
  data_ram_responder_if b1 ();

  data_ram_responder #(.ADDR_WIDTH(AW0), .LATENCY(L0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  data_ram_responder #(.ADDR_WIDTH(AW1), .LATENCY(L1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic        cs_r [2];
  logic        we_r [2];
  logic [2:0]  f_r  [2];
  logic [31:0] a_r  [2];
  logic [31:0] d_r  [2];
  logic        stall_w [2];
  logic        ack_w   [2];
  logic        err_w   [2];
  logic [31:0] dout_w  [2];

  assign b0.cs = cs_r[0]; assign b0.we = we_r[0]; assign b0.bhw = f_r[0];
  assign b0.addr = a_r[0]; assign b0.din = d_r[0];
  assign b1.cs = cs_r[1]; assign b1.we = we_r[1]; assign b1.bhw = f_r[1];
  assign b1.addr = a_r[1]; assign b1.din = d_r[1];
  assign stall_w[0] = b0.stall; assign ack_w[0] = b0.ack;
  assign err_w[0] = b0.err;     assign dout_w[0] = b0.dout;
  assign stall_w[1] = b1.stall; assign ack_w[1] = b1.ack;
  assign err_w[1] = b1.err;     assign dout_w[1] = b1.dout;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Timestamp model: a request accepted on edge n is performed on edge n+lat,
  // responds for one cycle, and the next acceptance can happen no earlier than n+lat+1.
  function automatic int lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction
  function automatic int nbytes_mem(input int k);
    return (k == 0) ? (4 << AW0) : (4 << AW1);
  endfunction
  function automatic int bidx(input int k, input logic [31:0] a);
    return int'(a[15:0]) & (nbytes_mem(k) - 1);
  endfunction
  function automatic int acc_size(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction
  function automatic bit is_bad(input logic [2:0] f, input logic [31:0] a);
    return (f == 3'b011) || (f == 3'b110) || (f == 3'b111) || ((int'(a[3:0]) % acc_size(f)) != 0);
  endfunction

  logic [7:0]  mmem [2][4096];
  int          ecount;
  bit          acc_v [2];
  int          acc_e [2];
  bit          r_we  [2];
  logic [2:0]  r_f   [2];
  logic [31:0] r_a   [2];
  logic [31:0] r_d   [2];
  logic        e_stall [2];
  logic        e_ack   [2];
  logic        e_err   [2];
  logic [31:0] e_dout  [2];

  function automatic logic [31:0] load_val(input int k, input logic [2:0] f, input logic [31:0] a);
    logic [7:0]  b0v, b1v;
    logic [31:0] w;
    int          i;
    i   = bidx(k, a);
    b0v = mmem[k][i];
    b1v = (f[1:0] != 2'b00) ? mmem[k][i+1] : 8'h00;
    w   = (f[1:0] == 2'b10) ? {mmem[k][i+3], mmem[k][i+2], b1v, b0v} : 32'h0;
    case (f)
      3'b000:  return {{24{b0v[7]}}, b0v};
      3'b100:  return {24'h0, b0v};
      3'b001:  return {{16{b1v[7]}}, b1v, b0v};
      3'b101:  return {16'h0, b1v, b0v};
      default: return w;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecount <= 0;
      for (int k = 0; k < 2; k++) begin
        acc_v[k] <= 1'b0; acc_e[k] <= 0;
        e_stall[k] <= 1'b0; e_ack[k] <= 1'b0; e_err[k] <= 1'b0; e_dout[k] <= '0;
      end
    end else begin
      ecount <= ecount + 1;
      for (int k = 0; k < 2; k++) begin
        e_ack[k] <= acc_v[k] && (ecount + 1 == acc_e[k] + lat(k));
        e_stall[k] <= (cs_r[k] && (!acc_v[k] || ecount + 1 > acc_e[k] + lat(k))) ||
                      (acc_v[k] && ecount + 1 < acc_e[k] + lat(k));
        if (acc_v[k] && (ecount + 1 == acc_e[k] + lat(k))) begin
          e_err[k] <= is_bad(r_f[k], r_a[k]);
          if (!is_bad(r_f[k], r_a[k])) begin
            if (r_we[k]) begin
              for (int j = 0; j < 4; j++)
                if (j < acc_size(r_f[k])) mmem[k][bidx(k, r_a[k]) + j] <= r_d[k][8*j +: 8];
            end else begin
              e_dout[k] <= load_val(k, r_f[k], r_a[k]);
            end
          end
        end
        if (cs_r[k] && (!acc_v[k] || ecount + 1 > acc_e[k] + lat(k))) begin
          acc_v[k] <= 1'b1; acc_e[k] <= ecount + 1;
          r_we[k] <= we_r[k]; r_f[k] <= f_r[k]; r_a[k] <= a_r[k]; r_d[k] <= d_r[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("cyc_stall", k, 32'(stall_w[k]), 32'(e_stall[k]));
        chk("cyc_ack", k, 32'(ack_w[k]), 32'(e_ack[k]));
        chk("cyc_dout", k, dout_w[k], e_dout[k]);
        if (e_ack[k]) chk("cyc_err", k, 32'(err_w[k]), 32'(e_err[k]));
      end
    end
  end

  task automatic req(input int k, input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, output int waits, output logic e, output logic [31:0] q);
    @(negedge clk);
    cs_r[k] = 1'b1; we_r[k] = w; f_r[k] = f; a_r[k] = a; d_r[k] = d;
    @(negedge clk);
    cs_r[k] = 1'b0;
    waits = 0;
    e = 1'bx;
    q = 'x;
    while (waits < 20) begin
      @(negedge clk);
      waits++;
      if (ack_w[k]) begin
        e = err_w[k];
        q = dout_w[k];
        break;
      end
    end
    if (waits >= 20) begin
      n_chk++; n_err++;
      $display("FAIL ack_timeout dut%0d: got no ack expected ack within 20 cycles", k);
    end
  endtask

  int          wt;
  logic        er;
  logic [31:0] q;
  int          rises;
  logic        prev;

  initial begin
    for (int k = 0; k < 2; k++) begin
      cs_r[k] = 1'b0; we_r[k] = 1'b0; f_r[k] = 3'b010; a_r[k] = '0; d_r[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_stall", k, 32'(stall_w[k]), 32'd0);
      chk("rst_ack", k, 32'(ack_w[k]), 32'd0);
      chk("rst_err", k, 32'(err_w[k]), 32'd0);
      chk("rst_dout", k, dout_w[k], 32'd0);
    end

    req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, wt, er, q);
    chk("sw_latency", 0, 32'(wt), 32'd3);
    chk("sw_err", 0, 32'(er), 32'd0);
    req(0, 1'b0, 3'b010, 32'h10, 32'h0, wt, er, q);
    chk("lw_latency", 0, 32'(wt), 32'd3);
    chk("lw_dout", 0, q, 32'hDEADBEEF);

    req(0, 1'b1, 3'b000, 32'h11, 32'h80, wt, er, q);
    req(0, 1'b0, 3'b010, 32'h10, 32'h0, wt, er, q);
    chk("sb_word", 0, q, 32'hDEAD80EF);
    req(0, 1'b0, 3'b000, 32'h11, 32'h0, wt, er, q);
    chk("lb", 0, q, 32'hFFFFFF80);
    req(0, 1'b0, 3'b100, 32'h11, 32'h0, wt, er, q);
    chk("lbu", 0, q, 32'h00000080);
    req(0, 1'b0, 3'b101, 32'h12, 32'h0, wt, er, q);
    chk("lhu", 0, q, 32'h0000DEAD);
    req(0, 1'b0, 3'b001, 32'h12, 32'h0, wt, er, q);
    chk("lh", 0, q, 32'hFFFFDEAD);

    req(0, 1'b1, 3'b010, 32'h13, 32'h01234567, wt, er, q);
    chk("sw_misal_err", 0, 32'(er), 32'd1);
    req(0, 1'b0, 3'b010, 32'h10, 32'h0, wt, er, q);
    chk("sw_misal_kept", 0, q, 32'hDEAD80EF);
    req(0, 1'b0, 3'b001, 32'h11, 32'h0, wt, er, q);
    chk("lh_misal_err", 0, 32'(er), 32'd1);
    chk("lh_misal_dout", 0, q, 32'hDEAD80EF);
    req(0, 1'b0, 3'b011, 32'h10, 32'h0, wt, er, q);
    chk("bhw011_err", 0, 32'(er), 32'd1);

    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (stall_w[0] && !prev) rises++;
      prev = stall_w[0];
      if (i < 16) begin
        cs_r[0] = 1'b1;
        we_r[0] = ((i / 4) % 2 == 0);
        f_r[0]  = 3'b010;
        a_r[0]  = (i % 4 == 0) ? 32'h40 : 32'h80 + 32'(4 * i);
        d_r[0]  = 32'h10000000 + 32'(i);
      end else begin
        cs_r[0] = 1'b0;
      end
    end
    chk("b2b_accepts", 0, 32'(rises), 32'd4);
    req(0, 1'b0, 3'b010, 32'h40, 32'h0, wt, er, q);
    chk("b2b_last_store", 0, q, 32'h10000008);

    req(0, 1'b1, 3'b010, 32'h20, 32'h12345678, wt, er, q);
    @(negedge clk);
    cs_r[0] = 1'b1; we_r[0] = 1'b1; f_r[0] = 3'b010; a_r[0] = 32'h20; d_r[0] = 32'hCAFEF00D;
    @(negedge clk);
    cs_r[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_stall", 0, 32'(stall_w[0]), 32'd0);
    chk("midrst_ack", 0, 32'(ack_w[0]), 32'd0);
    chk("midrst_err", 0, 32'(err_w[0]), 32'd0);
    chk("midrst_dout", 0, dout_w[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req(0, 1'b0, 3'b010, 32'h20, 32'h0, wt, er, q);
    chk("midrst_nocommit", 0, q, 32'h12345678);

    req(1, 1'b1, 3'b010, 32'h40, 32'hA5A55A5A, wt, er, q);
    chk("l1_sw_latency", 1, 32'(wt), 32'd1);
    req(1, 1'b0, 3'b010, 32'h00, 32'h0, wt, er, q);
    chk("l1_alias", 1, q, 32'hA5A55A5A);
    chk("l1_lw_latency", 1, 32'(wt), 32'd1);
    req(1, 1'b0, 3'b000, 32'h43, 32'h0, wt, er, q);
    chk("l1_lb_alias", 1, q, 32'hFFFFFFA5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder side of the functional-unit memory handshake (cs/we/addr/din -> dout/stall/ack) used by the memory functional unit.
- Models a byte-addressable data RAM with a fixed, parameterised access latency, so that out-of-order/scoreboard cores see realistic multi-cycle memory.
- Supports RISC-V byte/half/word loads and stores selected by bhw, with alignment checking.
- Sits directly below the memory FU and replaces the plain RAM instance when latency modelling is needed.

Parameters:
- ADDR_WIDTH, 10, word-index bits; depth = 2^ADDR_WIDTH 32-bit words.
- LATENCY, 3, rising edges from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- cs  input  1  request valid; sampled only when the block is idle or responding.
- we  input  1  1 = store, 0 = load.
- bhw  input  3  access type (RISC-V funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  byte address.
- din  input  32  store data, right-aligned.
- dout  output  32  load result, extended to 32 bits; held between loads.
- stall  output  1  request in flight; new cs is ignored.
- ack  output  1  one-cycle response pulse.
- err  output  1  misaligned address or illegal bhw; valid only while ack=1.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, stall=0, ack=0, err=0, dout=0. Memory array is not cleared.
- Reset mid-operation aborts the in-flight request. A store is never committed unless it reached edge E_L (defined below) before reset.
- States:
  - IDLE: stall=0, ack=0.
  - BUSY: stall=1, ack=0.
  - RESP: stall=0, ack=1.
- Acceptance, edge E0: a rising edge in IDLE or RESP with cs=1.
  - Registers we, bhw, addr, din.
  - Loads the counter with LATENCY-1 and enters BUSY.
- In BUSY the counter decrements each edge. At the edge where it is 0 (edge E_L, LATENCY edges after E0):
  - the access is performed, and
  - the state moves to RESP.
- RESP lasts exactly one cycle:
  - cs=1 at the next edge: accept a new request (back-to-back, one request per LATENCY+1 cycles).
  - Otherwise return to IDLE.
- With LATENCY=1, BUSY lasts one cycle.
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2].
  - Upper address bits are ignored, so addresses alias modulo 4*2^ADDR_WIDTH.
  - Byte lane = addr[1:0].
- Error conditions, all detected at E_L:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=00.
  - bhw in {011,110,111}.
- On error: no memory write, dout unchanged, err=1 during the RESP cycle.
- Store (we=1, no error), written at E_L:
  - B writes din[7:0] to the addressed lane.
  - H writes din[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - W writes all 4 lanes.
  - Other lanes of the word are preserved.
  - dout unchanged.
- Load (we=0, no error), dout updated at E_L:
  - B: sign-extend the addressed byte.
  - BU: zero-extend the addressed byte.
  - H: sign-extend the addressed halfword.
  - HU: zero-extend the addressed halfword.
  - W: the full word.
- Load data reflects memory contents at E_L, including any store committed at an earlier edge.
- cs while BUSY is ignored (no queuing). The requester must hold or re-issue the request until stall=0.
- Request fields are captured only at E0; input changes during BUSY have no effect.

Test Plan:
- Reset, then store W addr=0x10 din=0xDEADBEEF at E0, LATENCY=3:
  - stall=1 for cycles E0..E3, then ack=1, err=0 for exactly one cycle.
  - Load W 0x10 -> dout=0xDEADBEEF, ack 3 edges after its own acceptance.
- After the above:
  - store B addr=0x11 din=0x80 -> word 0xDEAD80EF.
  - Load B 0x11 -> 0xFFFFFF80.
  - Load BU 0x11 -> 0x00000080.
  - Load HU 0x12 -> 0x0000DEAD.
  - Load H 0x12 -> 0xFFFFDEAD.
- Misaligned cases:
  - Store W addr=0x13 -> ack=1, err=1, and the word at 0x10 is unchanged.
  - Load H addr=0x11 -> err=1, dout keeps its previous value.
  - bhw=011 -> err=1.
- Back-to-back: cs held high continuously with alternating stores/loads -> acceptances exactly LATENCY+1 edges apart. A cs pulse issued during BUSY with a different addr is ignored.
- Assert rst=0 mid-BUSY of a store to 0x20 (previous contents 0x12345678):
  - stall, ack, err and dout drop to 0 immediately.
  - A later load W 0x20 returns 0x12345678.
- LATENCY=1 and ADDR_WIDTH=4: a store to 0x40 aliases to 0x00. Load W 0x00 returns the stored value, ack 1 edge after acceptance.
